// File: rtl/uo_rr_arbiter.sv
// Round-robin arbiter that shares the registered uo_out word between NREQ requesters.
// Each granted word is presented for max(hold_cycles,1) cycles before the next grant.
module uo_rr_arbiter #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned HOLD_W = 4,
   parameter int unsigned SRC_W  = $clog2(NREQ)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NREQ-1:0]       i_req_valid,
   input  logic [NREQ*WIDTH-1:0] i_req_data,
   output logic [NREQ-1:0]       o_req_ready,
   input  logic [HOLD_W-1:0]     i_hold_cycles,
   output logic [WIDTH-1:0]      o_out_data,
   output logic                  o_out_valid,
   output logic [SRC_W-1:0]      o_out_src,
   output logic                  o_busy
);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic [HOLD_W-1:0]   r_cnt;
   logic [SRC_W-1:0]    r_last;
   logic [WIDTH-1:0]    r_out_data;
   logic                r_out_valid;
   logic [SRC_W-1:0]    r_out_src;

   logic                w_found;
   logic [SRC_W-1:0]    w_idx;
   logic [WIDTH-1:0]    w_word;
   logic [NREQ-1:0]     w_onehot;
   logic                w_window;
   logic                w_xfer;

   // Winner is the valid requester with the smallest rotational distance past r_last.
   always_comb begin : grant_search
      int best_d;
      int d;
      best_d   = int'(NREQ);
      w_idx    = '0;
      w_word   = '0;
      w_onehot = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         d = (i + 2 * int'(NREQ) - int'(r_last) - 1) % int'(NREQ);
         if (i_req_valid[i] && (d < best_d)) begin
            best_d      = d;
            w_idx       = SRC_W'(i);
            w_word      = i_req_data[i*WIDTH +: WIDTH];
            w_onehot    = '0;
            w_onehot[i] = 1'b1;
         end
      end
      w_found = (best_d < int'(NREQ));
   end

   assign w_window = !i_rst && ((r_state == StIdle) || (r_cnt == '0));
   assign w_xfer   = w_window && w_found;

   // FSM: state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: if (w_xfer) w_state_next = StHold;
         StHold: if (r_cnt == '0) w_state_next = w_xfer ? StHold : StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      o_req_ready = w_window ? w_onehot : '0;
      o_busy      = (r_state == StHold);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_last      <= SRC_W'(NREQ - 1);
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_src   <= '0;
      end else if (w_xfer) begin
         r_cnt       <= (i_hold_cycles == '0) ? '0 : i_hold_cycles - 1'b1;
         r_last      <= w_idx;
         r_out_data  <= w_word;
         r_out_valid <= 1'b1;
         r_out_src   <= w_idx;
      end else if (r_state == StHold) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_out_data  = r_out_data;
   assign o_out_valid = r_out_valid;
   assign o_out_src   = r_out_src;

endmodule

// File: tb/tb_uo_rr_arbiter.sv
// Directed bench for uo_rr_arbiter: reset, single word, round-robin, hold config, drop.
module tb_uo_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [3:0]  hold_cycles;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [1:0]  out_src;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   uo_rr_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_W(4)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req_valid   (req_valid),
      .i_req_data    (req_data),
      .o_req_ready   (req_ready),
      .i_hold_cycles (hold_cycles),
      .o_out_data    (out_data),
      .o_out_valid   (out_valid),
      .o_out_src     (out_src),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 4'b0000;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      req_valid   = 4'b1111;
      hold_cycles = 4'd3;
      req_data    = {8'h43, 8'h32, 8'h21, 8'h10};
      tick();
      tick();
      n_vec++;
      if (req_ready !== 4'b0000) begin
         n_err++; $display("FAIL reset_ready got %b want 0000", req_ready);
      end
      n_vec++;
      if (out_data !== 8'h00) begin
         n_err++; $display("FAIL reset_data got %h want 00", out_data);
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_valid got %b want 0", out_valid);
      end
      n_vec++;
      if (out_src !== 2'd0) begin
         n_err++; $display("FAIL reset_src got %0d want 0", out_src);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL reset_busy got %b want 0", busy);
      end
      req_valid = 4'b0000;
      rst       = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      hold_cycles = 4'd3;
      req_data    = {8'h00, 8'hA5, 8'h00, 8'h00};
      req_valid   = 4'b0100;
      #1;
      n_vec++;
      if (req_ready !== 4'b0100) begin
         n_err++; $display("FAIL single_ready got %b want 0100", req_ready);
      end
      tick();
      req_valid = 4'b0000;
      #1;
      n_vec++;
      if (out_data !== 8'hA5 || out_src !== 2'd2 || busy !== 1'b1) begin
         n_err++; $display("FAIL single_word got %h/%0d/%b want a5/2/1", out_data, out_src, busy);
      end
      for (int c = 1; c <= 3; c++) begin
         n_vec++;
         if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL single_hold cycle %0d got %b want 1", c, out_valid);
         end
         tick();
      end
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL single_end got v=%b b=%b want 0/0", out_valid, busy);
      end
      n_vec++;
      if (out_data !== 8'hA5 || out_src !== 2'd2) begin
         n_err++; $display("FAIL single_retain got %h/%0d want a5/2", out_data, out_src);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_src;
      logic [7:0] exp_data;
      do_reset();
      hold_cycles = 4'd2;
      req_data    = {8'h43, 8'h32, 8'h21, 8'h10};
      req_valid   = 4'b1111;
      tick();
      for (int c = 0; c < 10; c++) begin
         exp_src  = 2'((c / 2) % 4);
         exp_data = 8'h10 + 8'h11 * {6'd0, exp_src};
         n_vec++;
         if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== exp_data) begin
            n_err++;
            $display("FAIL rr cycle %0d got v=%b src=%0d data=%h want 1/%0d/%h",
                     c, out_valid, out_src, out_data, exp_src, exp_data);
         end
         if (c == 9) req_valid = 4'b0000;
         tick();
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL rr_drain got %b want 0", out_valid);
      end
   endtask

   task automatic test_hold01();
      logic [1:0] exp_src;
      do_reset();
      hold_cycles = 4'd0;
      req_data    = {8'h43, 8'h32, 8'h21, 8'h10};
      req_valid   = 4'b1010;
      #1;
      n_vec++;
      if (req_ready !== 4'b0010) begin
         n_err++; $display("FAIL h0_ready got %b want 0010", req_ready);
      end
      tick();
      for (int c = 0; c < 4; c++) begin
         exp_src = (c % 2 == 0) ? 2'd1 : 2'd3;
         n_vec++;
         if (out_valid !== 1'b1 || out_src !== exp_src) begin
            n_err++;
            $display("FAIL h0 cycle %0d got v=%b src=%0d want 1/%0d", c, out_valid, out_src, exp_src);
         end
         if (c == 3) hold_cycles = 4'd5;
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_src !== 2'd1) begin
            n_err++;
            $display("FAIL h5 cycle %0d got v=%b src=%0d want 1/1", c, out_valid, out_src);
         end
         tick();
      end
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== 2'd3) begin
         n_err++; $display("FAIL h5_next got v=%b src=%0d want 1/3", out_valid, out_src);
      end
   endtask

   task automatic test_mid_hold();
      do_reset();
      hold_cycles = 4'd8;
      req_data    = {8'h43, 8'h32, 8'h21, 8'h10};
      req_valid   = 4'b0001;
      tick();
      req_valid = 4'b0000;
      for (int c = 1; c <= 8; c++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== 8'h10) begin
            n_err++;
            $display("FAIL mid_hold cycle %0d got v=%b d=%h want 1/10", c, out_valid, out_data);
         end
         if (c == 3) hold_cycles = 4'd2;
         tick();
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL mid_hold_end got %b want 0", out_valid);
      end
      // Second word: reset lands in the 4th hold cycle.
      hold_cycles = 4'd8;
      req_valid   = 4'b0100;
      tick();
      req_valid = 4'b0000;
      for (int c = 1; c <= 3; c++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_src !== 2'd2) begin
            n_err++;
            $display("FAIL rst_hold cycle %0d got v=%b src=%0d want 1/2", c, out_valid, out_src);
         end
         tick();
      end
      rst       = 1'b1;
      req_valid = 4'b1111;
      #1;
      n_vec++;
      if (req_ready !== 4'b0000) begin
         n_err++; $display("FAIL rst_ready got %b want 0000", req_ready);
      end
      tick();
      rst = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_drop got v=%b d=%h b=%b want 0/00/0", out_valid, out_data, busy);
      end
      n_vec++;
      if (req_ready !== 4'b0001) begin
         n_err++; $display("FAIL rst_first_ready got %b want 0001", req_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'h10) begin
         n_err++;
         $display("FAIL rst_first got v=%b src=%0d d=%h want 1/0/10", out_valid, out_src, out_data);
      end
   endtask

   task automatic test_drop();
      logic [3:0] exp_ready;
      do_reset();
      hold_cycles = 4'd4;
      req_data    = {8'h43, 8'h32, 8'h21, 8'h10};
      req_valid   = 4'b0001;
      tick();
      for (int c = 1; c <= 8; c++) begin
         req_valid = (c == 2) ? 4'b0101 : 4'b0001;
         #1;
         exp_ready = (c % 4 == 0) ? 4'b0001 : 4'b0000;
         n_vec++;
         if (req_ready !== exp_ready) begin
            n_err++;
            $display("FAIL drop_ready cycle %0d got %b want %b", c, req_ready, exp_ready);
         end
         n_vec++;
         if (out_valid !== 1'b1 || out_src !== 2'd0) begin
            n_err++;
            $display("FAIL drop_src cycle %0d got v=%b src=%0d want 1/0", c, out_valid, out_src);
         end
         tick();
      end
      do_reset();
   endtask

   initial begin
      rst         = 1'b1;
      req_valid   = 4'b0000;
      req_data    = '0;
      hold_cycles = 4'd1;
      test_reset();
      test_single();
      test_round_robin();
      test_hold01();
      test_mid_hold();
      test_drop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
